// File: rtl/bike_counter_pkg.sv
// Shared types for the bike down-counter: FSM state encoding.
package bike_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bike_counter_dec_if.sv
// Control/status bundle between the counter and its controller.
interface bike_counter_dec_if #(
    parameter int SIZE = 5
);
    logic            start;
    logic [SIZE-1:0] load_val;
    logic            enable;
    logic            abort;
    logic [SIZE-1:0] cnt_out;
    logic            busy;
    logic            done;
    logic            wrap_pulse;

    modport master (
        output start, load_val, enable, abort,
        input  cnt_out, busy, done, wrap_pulse
    );

    modport slave (
        input  start, load_val, enable, abort,
        output cnt_out, busy, done, wrap_pulse
    );
endinterface

// File: rtl/bike_counter_dec.sv
// Loadable down-counter with IDLE/RUN/DONE FSM; one-shot or barrel reload.
// All outputs come straight from registers or a decode of the state register.
module bike_counter_dec
    import bike_counter_pkg::*;
#(
    parameter int SIZE      = 5,
    parameter int MAX_VALUE = 20,
    parameter int WRAP      = 0
) (
    input  logic                  clk,
    input  logic                  resetn,
    bike_counter_dec_if.slave     bus
);

    localparam logic [SIZE-1:0] MAX_CNT = SIZE'(MAX_VALUE);

    state_e          state_q, state_d;
    logic [SIZE-1:0] cnt_q,   cnt_d;
    logic            wrap_q,  wrap_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    // Clamp so the count can never exceed MAX_VALUE.
                    cnt_d   = (bus.load_val > MAX_CNT) ? MAX_CNT : bus.load_val;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (bus.enable) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - SIZE'(1);
                    end else if (WRAP != 0) begin
                        cnt_d  = MAX_CNT;
                        wrap_d = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.cnt_out    = cnt_q;
    assign bus.busy       = (state_q == ST_RUN);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.wrap_pulse = wrap_q;

endmodule

// File: tb/tb_bike_counter_dec.sv
// Directed checks of the one-shot (table) and barrel (hand sequence) counters.
module tb_bike_counter_dec;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    bike_counter_dec_if #(.SIZE(5)) if0 ();
    bike_counter_dec_if #(.SIZE(5)) if1 ();

    bike_counter_dec #(.SIZE(5), .MAX_VALUE(20), .WRAP(0)) dut0 (
        .clk(clk), .resetn(resetn), .bus(if0)
    );
    bike_counter_dec #(.SIZE(5), .MAX_VALUE(20), .WRAP(1)) dut1 (
        .clk(clk), .resetn(resetn), .bus(if1)
    );

    typedef struct {
        logic       rstn;
        logic       start;
        logic [4:0] ld;
        logic       en;
        logic       ab;
        logic [4:0] e_cnt;
        logic       e_busy;
        logic       e_done;
        logic       e_wrap;
    } vec_t;

    localparam int NV = 36;
    vec_t vecs [NV];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(logic rstn, logic start, logic [4:0] ld, logic en, logic ab,
                                logic [4:0] e_cnt, logic e_busy, logic e_done, logic e_wrap);
        vec_t v;
        v.rstn = rstn; v.start = start; v.ld = ld; v.en = en; v.ab = ab;
        v.e_cnt = e_cnt; v.e_busy = e_busy; v.e_done = e_done; v.e_wrap = e_wrap;
        return v;
    endfunction

    task automatic check(string name, logic [4:0] cnt, logic busy, logic done, logic wrap,
                         logic [4:0] e_cnt, logic e_busy, logic e_done, logic e_wrap);
        n_tests++;
        if (cnt !== e_cnt || busy !== e_busy || done !== e_done || wrap !== e_wrap) begin
            n_fail++;
            $display("FAIL %s: got cnt=%0d busy=%b done=%b wrap=%b, want cnt=%0d busy=%b done=%b wrap=%b",
                     name, cnt, busy, done, wrap, e_cnt, e_busy, e_done, e_wrap);
        end
    endtask

    task automatic drive1(logic start, logic [4:0] ld, logic en, logic ab);
        if1.start = start; if1.load_val = ld; if1.enable = en; if1.abort = ab;
    endtask

    task automatic step1(string name, logic [4:0] e_cnt, logic e_busy, logic e_done, logic e_wrap);
        @(posedge clk); #1;
        check(name, if1.cnt_out, if1.busy, if1.done, if1.wrap_pulse, e_cnt, e_busy, e_done, e_wrap);
    endtask

    initial begin
        //               rstn st ld     en ab   cnt  busy done wrap
        vecs[0]  = mk(0, 0, 5'd0,  0, 0,  5'd0,  0, 0, 0);
        vecs[1]  = mk(1, 1, 5'd5,  1, 0,  5'd5,  1, 0, 0);
        vecs[2]  = mk(1, 0, 5'd0,  1, 0,  5'd4,  1, 0, 0);
        vecs[3]  = mk(1, 0, 5'd0,  1, 0,  5'd3,  1, 0, 0);
        vecs[4]  = mk(1, 0, 5'd0,  1, 0,  5'd2,  1, 0, 0);
        vecs[5]  = mk(1, 0, 5'd0,  1, 0,  5'd1,  1, 0, 0);
        vecs[6]  = mk(1, 0, 5'd0,  1, 0,  5'd0,  1, 0, 0);
        vecs[7]  = mk(1, 0, 5'd0,  1, 0,  5'd0,  0, 1, 0);
        vecs[8]  = mk(1, 1, 5'd3,  1, 0,  5'd0,  0, 0, 0);
        vecs[9]  = mk(1, 1, 5'd31, 0, 0,  5'd20, 1, 0, 0);
        vecs[10] = mk(1, 0, 5'd0,  0, 0,  5'd20, 1, 0, 0);
        vecs[11] = mk(1, 1, 5'd2,  0, 0,  5'd20, 1, 0, 0);
        vecs[12] = mk(1, 0, 5'd0,  1, 1,  5'd0,  0, 0, 0);
        vecs[13] = mk(1, 0, 5'd0,  1, 1,  5'd0,  0, 0, 0);
        vecs[14] = mk(1, 1, 5'd4,  0, 0,  5'd4,  1, 0, 0);
        vecs[15] = mk(1, 0, 5'd0,  1, 0,  5'd3,  1, 0, 0);
        vecs[16] = mk(1, 0, 5'd0,  0, 0,  5'd3,  1, 0, 0);
        vecs[17] = mk(1, 0, 5'd0,  1, 0,  5'd2,  1, 0, 0);
        vecs[18] = mk(1, 0, 5'd0,  1, 0,  5'd1,  1, 0, 0);
        vecs[19] = mk(1, 0, 5'd0,  1, 0,  5'd0,  1, 0, 0);
        vecs[20] = mk(1, 0, 5'd0,  0, 0,  5'd0,  1, 0, 0);
        vecs[21] = mk(1, 0, 5'd0,  1, 0,  5'd0,  0, 1, 0);
        vecs[22] = mk(1, 0, 5'd0,  0, 0,  5'd0,  0, 0, 0);
        vecs[23] = mk(1, 1, 5'd3,  0, 0,  5'd3,  1, 0, 0);
        vecs[24] = mk(1, 0, 5'd0,  1, 1,  5'd0,  0, 0, 0);
        vecs[25] = mk(1, 0, 5'd0,  1, 0,  5'd0,  0, 0, 0);
        vecs[26] = mk(1, 1, 5'd0,  0, 0,  5'd0,  1, 0, 0);
        vecs[27] = mk(1, 0, 5'd0,  1, 0,  5'd0,  0, 1, 0);
        vecs[28] = mk(1, 0, 5'd0,  0, 0,  5'd0,  0, 0, 0);
        vecs[29] = mk(1, 1, 5'd9,  0, 0,  5'd9,  1, 0, 0);
        vecs[30] = mk(1, 0, 5'd0,  1, 0,  5'd8,  1, 0, 0);
        vecs[31] = mk(1, 0, 5'd0,  1, 0,  5'd7,  1, 0, 0);
        vecs[32] = mk(0, 1, 5'd4,  1, 0,  5'd0,  0, 0, 0);
        vecs[33] = mk(1, 0, 5'd0,  0, 0,  5'd0,  0, 0, 0);
        vecs[34] = mk(1, 1, 5'd20, 0, 0,  5'd20, 1, 0, 0);
        vecs[35] = mk(0, 0, 5'd0,  0, 0,  5'd0,  0, 0, 0);

        drive1(0, 5'd0, 0, 0);
        if0.start = 0; if0.load_val = '0; if0.enable = 0; if0.abort = 0;
        #1;

        for (int i = 0; i < NV; i++) begin
            resetn      = vecs[i].rstn;
            if0.start   = vecs[i].start;
            if0.load_val = vecs[i].ld;
            if0.enable  = vecs[i].en;
            if0.abort   = vecs[i].ab;
            @(posedge clk); #1;
            check($sformatf("oneshot_row%0d", i), if0.cnt_out, if0.busy, if0.done, if0.wrap_pulse,
                  vecs[i].e_cnt, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_wrap);
        end

        // Barrel mode: load 2, run through the reload and past it.
        resetn = 1'b1;
        drive1(1, 5'd2, 1, 0); step1("wrap_load2",   5'd2,  1, 0, 0);
        drive1(0, 5'd0, 1, 0); step1("wrap_cnt1",    5'd1,  1, 0, 0);
                               step1("wrap_cnt0",    5'd0,  1, 0, 0);
                               step1("wrap_reload",  5'd20, 1, 0, 1);
                               step1("wrap_cnt19",   5'd19, 1, 0, 0);
        drive1(0, 5'd0, 0, 0); step1("wrap_hold",    5'd19, 1, 0, 0);
        drive1(0, 5'd0, 1, 1); step1("wrap_abort",   5'd0,  0, 0, 0);
        // Load 0 reloads on the very first enabled edge.
        drive1(1, 5'd0, 0, 0); step1("wrap_load0",   5'd0,  1, 0, 0);
        drive1(0, 5'd0, 1, 0); step1("wrap_reload0", 5'd20, 1, 0, 1);
        drive1(0, 5'd0, 0, 0); step1("wrap_pulse_1cy", 5'd20, 1, 0, 0);
        // Reset while the reload pulse would fire suppresses it.
        drive1(0, 5'd0, 1, 0);
        repeat (20) @(posedge clk);
        #1;
        check("wrap_at_zero", if1.cnt_out, if1.busy, if1.done, if1.wrap_pulse, 5'd0, 1, 0, 0);
        resetn = 1'b0;         step1("wrap_reset",   5'd0,  0, 0, 0);
        resetn = 1'b1;
        drive1(0, 5'd0, 0, 0); step1("wrap_post_rst", 5'd0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bike_counter_dec.md
BIKE_COUNTER_DEC -- requirements
Module: bike_counter_dec

Interface
REQ-001 Parameter SIZE, default 5, counter width in bits.
REQ-002 Parameter MAX_VALUE, default 20, maximum count value and wrap reload value; SHALL be < 2^SIZE.
REQ-003 Parameter WRAP, default 0; 0 = one-shot mode (stop at zero), 1 = barrel mode (reload MAX_VALUE).
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 resetn  input  1  synchronous, active-low reset.
REQ-006 start  input  1  load request; sampled only in IDLE.
REQ-007 load_val  input  SIZE  start value, captured with start.
REQ-008 enable  input  1  decrement step qualifier; honoured only in RUN.
REQ-009 abort  input  1  cancel current run; honoured only in RUN.
REQ-010 cnt_out  output  SIZE  current count, registered.
REQ-011 busy  output  1  high while in RUN, registered.
REQ-012 done  output  1  one-cycle pulse on one-shot completion, registered.
REQ-013 wrap_pulse  output  1  one-cycle pulse on barrel reload, registered.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 IDLE with start=1: count <= min(load_val, MAX_VALUE); next state RUN; otherwise remain IDLE and hold count.
REQ-016 RUN with abort=1: next state IDLE, count <= 0, no done or wrap_pulse; abort has priority over enable.
REQ-017 RUN, enable=1, count>0: count <= count-1; remain RUN.
REQ-018 RUN, enable=1, count==0, WRAP=0: next state DONE; count stays 0.
REQ-019 RUN, enable=1, count==0, WRAP=1: count <= MAX_VALUE; wrap_pulse=1 for that next cycle only; remain RUN.
REQ-020 RUN, enable=0, abort=0: count and state hold.
REQ-021 DONE: done=1 for exactly one cycle; next state IDLE unconditionally; count holds 0.
REQ-022 start SHALL be ignored in RUN and DONE; enable and abort SHALL be ignored in IDLE and DONE.
REQ-023 busy SHALL equal (state==RUN); first high in the cycle after start is sampled.
REQ-024 In one-shot mode, completion SHALL take exactly (loaded value + 1) enabled edges after entering RUN; load_val=0 completes on the first enabled edge.
REQ-025 Arithmetic SHALL be unsigned SIZE-bit; count SHALL never underflow or exceed MAX_VALUE.

Reset
REQ-026 resetn=0 at a rising edge SHALL force state IDLE, cnt_out=0, busy=0, done=0, wrap_pulse=0, overriding all other inputs.
REQ-027 Reset asserted mid-run SHALL discard the run without a done or wrap_pulse pulse.

Structure
REQ-028 FSM state enumeration typedef SHALL reside in shared package bike_counter_pkg.
REQ-029 No sub-module; a single module with one FSM register and one count register.

Verification
REQ-030 WRAP=0, start with load_val=5, enable held high -> cnt_out 5,4,3,2,1,0; done=1 one cycle after 6th enabled edge; busy low next cycle.
REQ-031 WRAP=1, MAX_VALUE=20, load_val=2, enable held high -> cnt_out 2,1,0,20,19; wrap_pulse=1 only in cycle cnt_out=20; done never asserted.
REQ-032 load_val=31 with MAX_VALUE=20 -> cnt_out=20 after start.
REQ-033 RUN at cnt_out=3, abort=1 and enable=1 together -> IDLE, cnt_out=0, busy=0, no done.
REQ-034 resetn=0 while RUN at cnt_out=7 -> next cycle all outputs 0, state IDLE; start during RUN is ignored (cnt_out unchanged).
REQ-035 enable toggled 1,0,1 from cnt_out=4 -> cnt_out 3,3,2.
